// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the instruction/data memory port arbiter.
//               Holds the arbiter FSM state encoding and the transaction
//               owner encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // The FSM has three states. They are encoded explicitly so that the
    // register width does not depend on the tool.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;

    // Identifies which requester owns the transaction in flight.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_grant
// Description : Combinational grant between the fetch (I) and data (D)
//               requesters. The default build uses fixed priority, with D
//               ahead of I. When MEM_ARB_RR_EN is defined, a tie goes to the
//               requester that was not granted last time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   i_fetch_valid,
    input  logic   i_data_valid,
`ifdef MEM_ARB_RR_EN
    input  owner_t i_last_owner,
`endif
    output logic   o_grant_fetch,
    output logic   o_grant_data
);

`ifdef MEM_ARB_RR_EN
    // A single requester always wins. A tie goes to the one not served last.
    always_comb begin
        o_grant_fetch = i_fetch_valid;
        o_grant_data  = i_data_valid;
        if (i_fetch_valid && i_data_valid) begin
            o_grant_data  = (i_last_owner == OWNER_I);
            o_grant_fetch = (i_last_owner == OWNER_D);
        end
    end
`else
    // Fixed priority: a data request always beats a fetch request.
    always_comb begin
        o_grant_data  = i_data_valid;
        o_grant_fetch = i_fetch_valid & ~i_data_valid;
    end
`endif

endmodule : mem_arb_grant
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between instruction fetch and
//               load/store requesters. At most one transaction is
//               outstanding at a time. Defining MEM_ARB_RR_EN selects a
//               round-robin tie-break instead of fixed D>I priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_req_ready,
    output logic                    i_rsp_valid,
    output logic [DATA_WIDTH-1:0]   i_rsp_rdata,
    input  logic                    d_req_valid,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic                    d_req_write,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_strb,
    output logic                    d_req_ready,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rsp_rdata,
    output logic                    m_req_valid,
    output logic [ADDR_WIDTH-1:0]   m_req_addr,
    output logic                    m_req_write,
    output logic [DATA_WIDTH-1:0]   m_req_wdata,
    output logic [DATA_WIDTH/8-1:0] m_req_strb,
    input  logic                    m_req_ready,
    input  logic                    m_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   m_rsp_rdata,
    output logic                    busy
);

    localparam int c_STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    owner_t                  r_owner;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_STRB_WIDTH-1:0] r_strb;
    logic                    w_grant_i;
    logic                    w_grant_d;

`ifdef MEM_ARB_RR_EN
    owner_t                  r_last_owner;
`endif

    mem_arb_grant u_grant (
        .i_fetch_valid (i_req_valid),
        .i_data_valid  (d_req_valid),
`ifdef MEM_ARB_RR_EN
        .i_last_owner  (r_last_owner),
`endif
        .o_grant_fetch (w_grant_i),
        .o_grant_data  (w_grant_d)
    );

    // State register. An asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs. Requester readies depend only on the
    // state and the requester valids, never on m_req_ready.
    always_comb begin
        w_state_nxt = r_state;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        m_req_valid = 1'b0;
        i_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                d_req_ready = d_req_valid & w_grant_d;
                i_req_ready = i_req_valid & w_grant_i;
                if (d_req_ready || i_req_ready) begin
                    w_state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                m_req_valid = 1'b1;
                if (m_req_ready) begin
                    w_state_nxt = ARB_RSP;
                end
            end
            ARB_RSP: begin
                if (m_rsp_valid) begin
                    if (r_owner == OWNER_D) begin
                        d_rsp_valid = 1'b1;
                    end else begin
                        i_rsp_valid = 1'b1;
                    end
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Capture the accepted request. A fetch always issues as a plain read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWNER_D;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (d_req_ready) begin
            r_owner <= OWNER_D;
            r_addr  <= d_req_addr;
            r_write <= d_req_write;
            r_wdata <= d_req_wdata;
            r_strb  <= d_req_strb;
        end else if (i_req_ready) begin
            r_owner <= OWNER_I;
            r_addr  <= i_req_addr;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who was served last, so that the next tie goes the other way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= OWNER_I;
        end else if (d_req_ready) begin
            r_last_owner <= OWNER_D;
        end else if (i_req_ready) begin
            r_last_owner <= OWNER_I;
        end
    end
`endif

    assign m_req_addr  = r_addr;
    assign m_req_write = r_write;
    assign m_req_wdata = r_wdata;
    assign m_req_strb  = r_strb;
    assign i_rsp_rdata = m_rsp_rdata;
    assign d_rsp_rdata = m_rsp_rdata;
    assign busy        = (r_state != ARB_IDLE);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. Expected
//               responses are queued when a request is accepted and checked
//               off when a response pulse appears. MEM_ARB_RR_EN selects the
//               round-robin expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } rsp_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_rdata;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_write;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_strb;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        m_req_valid;
    logic [31:0] m_req_addr;
    logic        m_req_write;
    logic [31:0] m_req_wdata;
    logic [3:0]  m_req_strb;
    logic        m_req_ready;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    rsp_exp_t    sb[$];

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_addr  (i_req_addr),
        .i_req_ready (i_req_ready),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_rdata (i_rsp_rdata),
        .d_req_valid (d_req_valid),
        .d_req_addr  (d_req_addr),
        .d_req_write (d_req_write),
        .d_req_wdata (d_req_wdata),
        .d_req_strb  (d_req_strb),
        .d_req_ready (d_req_ready),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_rdata (d_rsp_rdata),
        .m_req_valid (m_req_valid),
        .m_req_addr  (m_req_addr),
        .m_req_write (m_req_write),
        .m_req_wdata (m_req_wdata),
        .m_req_strb  (m_req_strb),
        .m_req_ready (m_req_ready),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_rdata (m_rsp_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge, and checks run on the falling edge.
    task automatic to_drv();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    // Scoreboard: every response pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (i_rsp_valid || d_rsp_valid) begin
            chk("rsp_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                rsp_exp_t e;
                e = sb.pop_front();
                chk("rsp_d_valid", {31'd0, d_rsp_valid}, {31'd0, e.is_d});
                chk("rsp_i_valid", {31'd0, i_rsp_valid}, {31'd0, ~e.is_d});
                chk("rsp_rdata", e.is_d ? d_rsp_rdata : i_rsp_rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_d2;
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_write = 1'b0;
        d_req_wdata = '0;   d_req_strb = '0;
        m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0;

        // Reset state
        to_drv(); to_neg();
        chk("rst_m_valid", {31'd0, m_req_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
        chk("rst_ready", {30'd0, i_req_ready, d_req_ready}, 32'd0);
        chk("rst_m_addr", m_req_addr, 32'd0);
        chk("rst_m_ctl", {23'd0, m_req_write, m_req_strb, 4'd0}, 32'd0);
        chk("rst_m_wdata", m_req_wdata, 32'd0);
        to_drv(); rst = 1'b0;

        // Single fetch with an always-ready, next-cycle memory
        i_req_valid = 1'b1; i_req_addr = 32'h100; m_req_ready = 1'b1;
        to_neg();
        chk("f_i_ready", {31'd0, i_req_ready}, 32'd1);
        chk("f_d_ready", {31'd0, d_req_ready}, 32'd0);
        chk("f_m_valid_n", {31'd0, m_req_valid}, 32'd0);
        sb.push_back('{is_d: 1'b0, data: 32'hDEADBEEF});
        to_drv(); i_req_valid = 1'b0;
        to_neg();
        chk("f_m_valid_n1", {31'd0, m_req_valid}, 32'd1);
        chk("f_m_addr", m_req_addr, 32'h100);
        chk("f_m_ctl", {27'd0, m_req_write, m_req_strb}, 32'd0);
        chk("f_m_wdata", m_req_wdata, 32'd0);
        chk("f_busy", {31'd0, busy}, 32'd1);
        to_drv(); m_rsp_valid = 1'b1; m_rsp_rdata = 32'hDEADBEEF;
        to_neg();
        chk("f_i_rsp", {31'd0, i_rsp_valid}, 32'd1);
        chk("f_d_rsp", {31'd0, d_rsp_valid}, 32'd0);
        to_drv(); m_rsp_valid = 1'b0;
        to_neg();
        chk("f_idle", {31'd0, busy}, 32'd0);

        // Store with m_req_ready held low for 4 cycles
        to_drv();
        d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_write = 1'b1;
        d_req_wdata = 32'h12345678; d_req_strb = 4'b0011; m_req_ready = 1'b0;
        to_neg();
        chk("s_d_ready", {31'd0, d_req_ready}, 32'd1);
        sb.push_back('{is_d: 1'b1, data: 32'hCAFE0001});
        to_drv(); d_req_valid = 1'b0; d_req_write = 1'b0; d_req_wdata = '0; d_req_strb = '0;
        for (int k = 0; k < 5; k++) begin
            to_neg();
            chk("s_m_valid", {31'd0, m_req_valid}, 32'd1);
            chk("s_m_addr", m_req_addr, 32'h2000);
            chk("s_m_wdata", m_req_wdata, 32'h12345678);
            chk("s_m_ctl", {27'd0, m_req_write, m_req_strb}, 32'h13);
            chk("s_busy", {31'd0, busy}, 32'd1);
            to_drv();
            m_req_ready = (k >= 3);
        end
        to_neg();
        chk("s_rsp_state_m_valid", {31'd0, m_req_valid}, 32'd0);
        to_drv(); m_rsp_valid = 1'b1; m_rsp_rdata = 32'hCAFE0001;
        to_neg();
        chk("s_d_rsp", {31'd0, d_rsp_valid}, 32'd1);
        to_drv();
        to_neg();
        chk("s_d_rsp_once", {31'd0, d_rsp_valid}, 32'd0);
        chk("s_busy_after", {31'd0, busy}, 32'd0);
        to_drv(); m_rsp_valid = 1'b0;

        // Both requesters held valid for two transactions, from reset
        rst = 1'b1;
        to_drv(); rst = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h300;
        d_req_valid = 1'b1; d_req_addr = 32'h400; m_req_ready = 1'b1;
        to_neg();
        chk("t1_d_ready", {31'd0, d_req_ready}, 32'd1);
        chk("t1_i_ready", {31'd0, i_req_ready}, 32'd0);
        sb.push_back('{is_d: 1'b1, data: 32'h11110000});
        to_drv();
        to_neg();
        chk("t1_ready_req", {30'd0, i_req_ready, d_req_ready}, 32'd0);
        chk("t1_m_addr", m_req_addr, 32'h400);
        to_drv(); m_rsp_valid = 1'b1; m_rsp_rdata = 32'h11110000;
        to_neg();
        chk("t1_ready_rsp", {30'd0, i_req_ready, d_req_ready}, 32'd0);
        to_drv(); m_rsp_valid = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_d2 = 1'b0;
`else
        exp_d2 = 1'b1;
`endif
        to_neg();
        chk("t2_d_ready", {31'd0, d_req_ready}, {31'd0, exp_d2});
        chk("t2_i_ready", {31'd0, i_req_ready}, {31'd0, ~exp_d2});
        sb.push_back('{is_d: exp_d2, data: 32'h22220000});
        to_drv(); i_req_valid = 1'b0; d_req_valid = 1'b0;
        to_neg();
        chk("t2_m_addr", m_req_addr, exp_d2 ? 32'h400 : 32'h300);
        to_drv(); m_rsp_valid = 1'b1; m_rsp_rdata = 32'h22220000;
        to_neg();
        to_drv(); m_rsp_valid = 1'b0;
        to_neg();
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // Spurious memory responses in IDLE and in REQ
        to_drv(); m_rsp_valid = 1'b1; m_rsp_rdata = 32'hBAD0BAD0;
        to_neg();
        chk("sp_idle_busy", {31'd0, busy}, 32'd0);
        chk("sp_idle_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
        to_drv(); i_req_valid = 1'b1; i_req_addr = 32'h500; m_req_ready = 1'b0;
        to_neg();
        chk("sp_i_ready", {31'd0, i_req_ready}, 32'd1);
        sb.push_back('{is_d: 1'b0, data: 32'h00000055});
        to_drv(); i_req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            to_neg();
            chk("sp_req_m_valid", {31'd0, m_req_valid}, 32'd1);
            chk("sp_req_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
            to_drv();
        end
        m_rsp_valid = 1'b0; m_req_ready = 1'b1;
        to_neg();
        chk("sp_still_req", {31'd0, m_req_valid}, 32'd1);
        to_drv(); m_rsp_valid = 1'b1; m_rsp_rdata = 32'h00000055;
        to_neg();
        chk("sp_i_rsp", {31'd0, i_rsp_valid}, 32'd1);
        to_drv(); m_rsp_valid = 1'b0;

        // Reset asserted while waiting in RSP
        d_req_valid = 1'b1; d_req_addr = 32'h600; d_req_write = 1'b0;
        to_neg();
        chk("r_d_ready", {31'd0, d_req_ready}, 32'd1);
        to_drv(); d_req_valid = 1'b0;
        to_neg();
        to_drv();
        to_neg();
        chk("r_in_rsp_busy", {31'd0, busy}, 32'd1);
        chk("r_in_rsp_m_valid", {31'd0, m_req_valid}, 32'd0);
        #2 rst = 1'b1;
        #1 chk("r_async_busy", {31'd0, busy}, 32'd0);
        to_drv(); rst = 1'b0; m_rsp_valid = 1'b1; m_rsp_rdata = 32'h66;
        to_neg();
        chk("r_late_rsp", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
        chk("r_late_busy", {31'd0, busy}, 32'd0);
        to_drv(); m_rsp_valid = 1'b0; d_req_valid = 1'b1; d_req_addr = 32'h700;
        to_neg();
        chk("r_next_ready", {31'd0, d_req_ready}, 32'd1);
        sb.push_back('{is_d: 1'b1, data: 32'h77});
        to_drv(); d_req_valid = 1'b0;
        to_neg();
        chk("r_next_addr", m_req_addr, 32'h700);
        to_drv(); m_rsp_valid = 1'b1; m_rsp_rdata = 32'h77;
        to_neg();
        to_drv(); m_rsp_valid = 1'b0;

        // Back-to-back loads: the second is accepted the cycle after the first response
        d_req_valid = 1'b1; d_req_addr = 32'h0;
        to_neg();
        chk("b_first_ready", {31'd0, d_req_ready}, 32'd1);
        sb.push_back('{is_d: 1'b1, data: 32'hA0});
        to_drv(); d_req_addr = 32'h4;
        to_neg();
        chk("b_held_ready", {31'd0, d_req_ready}, 32'd0);
        chk("b_first_addr", m_req_addr, 32'h0);
        to_drv(); m_rsp_valid = 1'b1; m_rsp_rdata = 32'hA0;
        to_neg();
        chk("b_first_rsp", {31'd0, d_rsp_valid}, 32'd1);
        chk("b_rsp_ready", {31'd0, d_req_ready}, 32'd0);
        to_drv(); m_rsp_valid = 1'b0;
        to_neg();
        chk("b_second_ready", {31'd0, d_req_ready}, 32'd1);
        sb.push_back('{is_d: 1'b1, data: 32'hA4});
        to_drv(); d_req_valid = 1'b0;
        to_neg();
        chk("b_second_addr", m_req_addr, 32'h4);
        to_drv(); m_rsp_valid = 1'b1; m_rsp_rdata = 32'hA4;
        to_neg();
        to_drv(); m_rsp_valid = 1'b0;
        to_neg();
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
